// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, LSB first.
// Each bit is held DIV cycles; burst framed by s_valid and a done pulse.
module piso_tx #(
    parameter int N   = 4,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] d_in,
    input  logic         load,
    output logic         ready,
    output logic         s_out,
    output logic         s_valid,
    output logic         done
);

    localparam int BW = $clog2(N) + 1;
    localparam int DW = $clog2(DIV) + 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [N-1:0]  sh;
    logic [N-1:0]  sh_nx;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_nx;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nx;
    logic          done_nx;
    logic          div_end;
    logic          bit_end;

    assign div_end = (div_cnt == DIV_LAST);
    assign bit_end = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sh_nx    = sh;
        bit_nx   = bit_cnt;
        div_nx   = div_cnt;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) begin
                    sh_nx    = d_in;
                    bit_nx   = '0;
                    div_nx   = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (div_end) begin
                    div_nx = '0;
                    sh_nx  = {1'b0, sh[N-1:1]};
                    bit_nx = bit_cnt + 1'b1;
                    if (bit_end) begin
                        bit_nx   = '0;
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                end else begin
                    div_nx = div_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh      <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            done    <= 1'b0;
        end else begin
            sh      <= sh_nx;
            bit_cnt <= bit_nx;
            div_cnt <= div_nx;
            done    <= done_nx;
        end
    end

    // outputs decode registered state only; s_out forced low outside a burst
    assign ready   = (state == IDLE);
    assign s_valid = (state == SHIFT);
    assign s_out   = s_valid & sh[0];

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: two piso_tx instances (N=4/DIV=1, N=8/DIV=3) driven with
// directed and random words, scoreboarded by a word-level serial model.
module tb_piso_tx;

    localparam int NA = 4;
    localparam int DA = 1;
    localparam int NB = 8;
    localparam int DB = 3;

    logic          clk;
    logic          reset;
    logic [NA-1:0] d_a;
    logic [NB-1:0] d_b;
    logic          load_a;
    logic          load_b;
    logic          ready_a;
    logic          ready_b;
    logic          s_out_a;
    logic          s_out_b;
    logic          s_valid_a;
    logic          s_valid_b;
    logic          done_a;
    logic          done_b;

    logic rdy[2];
    logic sv[2];
    logic so[2];
    logic dn[2];

    int total = 0;
    int bad = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    bit         act[2];
    int         cyc[2];
    logic [7:0] sr[2];
    logic [7:0] cur[2];
    logic       held[2];
    int         got_done[2];

    piso_tx #(.N(NA), .DIV(DA)) u_a (
        .clk     (clk),
        .reset   (reset),
        .d_in    (d_a),
        .load    (load_a),
        .ready   (ready_a),
        .s_out   (s_out_a),
        .s_valid (s_valid_a),
        .done    (done_a)
    );

    piso_tx #(.N(NB), .DIV(DB)) u_b (
        .clk     (clk),
        .reset   (reset),
        .d_in    (d_b),
        .load    (load_b),
        .ready   (ready_b),
        .s_out   (s_out_b),
        .s_valid (s_valid_b),
        .done    (done_b)
    );

    assign rdy[0] = ready_a;
    assign rdy[1] = ready_b;
    assign sv[0]  = s_valid_a;
    assign sv[1]  = s_valid_b;
    assign so[0]  = s_out_a;
    assign so[1]  = s_out_b;
    assign dn[0]  = done_a;
    assign dn[1]  = done_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Accepted words enter the scoreboard on the handshake edge.
    always @(posedge clk) begin
        if (!reset && load_a && ready_a) q0.push_back({4'b0, d_a});
        if (!reset && load_b && ready_b) q1.push_back(d_b);
    end

    task automatic mon_step(input int id);
        int n;
        int d;
        int c;
        n = (id == 0) ? NA : NB;
        d = (id == 0) ? DA : DB;
        if (reset) begin
            act[id] = 0;
            return;
        end
        if (!act[id]) begin
            chk("stray_done", 32'(dn[id]), 0);
            if (sv[id]) begin
                act[id] = 1;
                cyc[id] = 0;
                sr[id]  = '0;
                if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                    total++;
                    bad++;
                    cur[id] = '0;
                    $display("FAIL unexpected_burst: inst=%0d got burst expected none", id);
                end else if (id == 0) begin
                    cur[id] = q0.pop_front();
                end else begin
                    cur[id] = q1.pop_front();
                end
            end
        end
        if (act[id]) begin
            c = cyc[id];
            if (c < n * d) begin
                chk("busy_flags", 32'({sv[id], rdy[id]}), 2);
                if (c % d == 0) begin
                    chk("bit", 32'(so[id]), 32'(cur[id][c / d]));
                    held[id] = so[id];
                    sr[id] = (sr[id] >> 1) | (8'(so[id]) << (n - 1));
                end else begin
                    chk("bit_hold", 32'(so[id]), 32'(held[id]));
                end
                cyc[id]++;
            end else begin
                chk("done_cycle", 32'({sv[id], so[id], dn[id], rdy[id]}), 3);
                chk("loopback", 32'(sr[id]), 32'(cur[id]));
                got_done[id]++;
                act[id] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0);
        mon_step(1);
    end

    task automatic drive(input int id, input logic [7:0] w, input logic ld);
        if (id == 0) begin
            d_a    = w[3:0];
            load_a = ld;
        end else begin
            d_b    = w;
            load_b = ld;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input int id, input logic [7:0] w);
        int t;
        t = 0;
        while (!rdy[id] && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready_timeout", 32'(rdy[id]), 1);
        drive(id, w, 1'b1);
        @(negedge clk);
        drive(id, $urandom, 1'b0);
    endtask

    task automatic wait_idle(input int id);
        int t;
        bit idle;
        t = 0;
        idle = 0;
        while (!idle && t < 500) begin
            @(negedge clk);
            t++;
            idle = !act[id] && rdy[id] &&
                   ((id == 0) ? (q0.size() == 0) : (q1.size() == 0));
        end
        chk("drain_timeout", 32'(idle), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int snap;
        int t;
        int id;
        reset  = 1'b1;
        d_a    = '0;
        d_b    = '0;
        load_a = 1'b0;
        load_b = 1'b0;
        #23 reset = 1'b0;
        @(negedge clk);
        chk("reset_a", 32'({rdy[0], sv[0], so[0], dn[0]}), 8);
        chk("reset_b", 32'({rdy[1], sv[1], so[1], dn[1]}), 8);
        repeat (3) @(negedge clk);
        chk("idle_hold_a", 32'({rdy[0], sv[0], so[0], dn[0]}), 8);

        // single word, N=4
        send(0, 8'h0B);
        wait_idle(0);

        // divided rate, N=8 DIV=3
        send(1, 8'hA5);
        wait_idle(1);

        // back-to-back with load held; second word presented on done
        drive(0, 8'h0C, 1'b1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!dn[0] && t < 50);
        chk("b2b_done_seen", 32'(dn[0]), 1);
        drive(0, 8'h03, 1'b1);
        @(negedge clk);
        drive(0, 8'h00, 1'b0);
        chk("b2b_start", 32'({sv[0], so[0]}), 3);
        wait_idle(0);

        // load mid-word is ignored
        snap = got_done[0];
        send(0, 8'h06);
        @(negedge clk);
        drive(0, 8'h0F, 1'b1);
        @(negedge clk);
        drive(0, 8'h00, 1'b0);
        wait_idle(0);
        repeat (3) @(negedge clk);
        chk("one_done", got_done[0] - snap, 1);

        // async reset mid-word, then a clean word
        snap = got_done[1];
        send(1, 8'hFF);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset", 32'({rdy[1], sv[1], so[1], dn[1]}), 8);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_hold", 32'({rdy[1], sv[1], so[1], dn[1]}), 8);
        send(1, 8'h01);
        wait_idle(1);
        chk("reset_no_done", got_done[1] - snap, 1);

        // random words with random stray loads
        for (int i = 0; i < 24; i++) begin
            id = int'($urandom_range(0, 1));
            send(id, 8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                drive(id, 8'($urandom), 1'b1);
                @(negedge clk);
                drive(id, 8'($urandom), 1'b0);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(0);
        wait_idle(1);
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
